// File: rtl/wishbone_sram_responder_pkg.sv
// Shared Wishbone B4 types: cycle-type and burst-type codes, responder
// FSM states, and the burst address generator.
package wishbone_types;

  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    CONST   = 3'b001,
    INCR    = 3'b010,
    EOB     = 3'b111
  } wb_cti_t;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    WRAP4  = 2'b01,
    WRAP8  = 2'b10,
    WRAP16 = 2'b11
  } wb_bte_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_resp_state_t;

  // Address of the beat after adr: linear bursts count through the whole
  // 30-bit word space, wrap bursts only cycle the low 2/3/4 bits.
  function automatic logic [29:0] wb_next_adr(input logic [29:0] adr, input wb_bte_t bte);
    logic [29:0] nxt;
    nxt = adr;
    case (bte)
      LINEAR: nxt      = adr + 30'd1;
      WRAP4:  nxt[1:0] = adr[1:0] + 2'd1;
      WRAP8:  nxt[2:0] = adr[2:0] + 3'd1;
      WRAP16: nxt[3:0] = adr[3:0] + 4'd1;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/wishbone_interface.sv
// Wishbone B4 bus bundle (32-bit data, word addressed) with master and
// slave views.
interface wishbone_interface;
  logic [29:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport slave (
    input  adr, dat_w, sel, cyc, stb, we, cti, bte,
    output dat_r, ack, err
  );

  modport master (
    output adr, dat_w, sel, cyc, stb, we, cti, bte,
    input  dat_r, ack, err
  );
endinterface

// File: rtl/wishbone_sram_responder_ram.sv
// 32-bit SRAM with four byte enables, separate write and read addresses,
// synchronous read with one cycle of latency, write-first on collision.
module byte_en_ram #(
  parameter  int unsigned DEPTH = 1024,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_q;

  assign o_rdata = r_q;

  // Byte-masked write port.
  // NOTE: the storage array has no reset so it maps onto block RAM; only
  // control state is cleared by rst_n.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we && i_be[i]) begin
        r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Registered read; a byte being written to the read address this cycle
  // is forwarded so the reader sees the new value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we && i_be[i] && (i_waddr == i_raddr)) begin
        r_q[8*i +: 8] <= i_wdata[8*i +: 8];
      end else begin
        r_q[8*i +: 8] <= r_mem[i_raddr][8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/wishbone_sram_responder.sv
// Wishbone B4 responder backed by byte-enabled SRAM. Handles classic
// cycles and registered-feedback incrementing bursts (linear, wrap-4/8/16)
// with optional wait states before the first beat; answers err outside
// the word window [BASE_WORD, BASE_WORD+DEPTH_WORDS).
module wishbone_sram_responder
  import wishbone_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [29:0] BASE_WORD   = 30'd0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  wishbone_interface.slave   wb
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  wb_resp_state_t r_state;
  logic [3:0]     r_wait_cnt;
  logic [29:0]    r_cur_adr;
  wb_bte_t        r_bte;

  logic [30:0]    w_cur_off;
  logic           w_in_range;
  logic           w_req;
  logic           w_ack;
  logic           w_err;
  logic           w_burst_next;
  logic [29:0]    w_next_adr;
  logic [29:0]    w_rd_adr;
  logic [AW-1:0]  w_rd_idx;
  logic [AW-1:0]  w_wr_idx;
  logic [31:0]    w_ram_q;

  // Range check done in 31 bits so addresses near 2^30 never alias low.
  assign w_cur_off  = {1'b0, r_cur_adr} - {1'b0, BASE_WORD};
  assign w_in_range = (r_cur_adr >= BASE_WORD) && (w_cur_off < 31'(DEPTH_WORDS));

  assign w_req        = wb.cyc & wb.stb;
  assign w_ack        = (r_state == RESP) & w_req & w_in_range;
  assign w_err        = (r_state == RESP) & w_req & ~w_in_range;
  assign w_burst_next = w_ack & (wb.cti == INCR);
  assign w_next_adr   = wb_next_adr(r_cur_adr, r_bte);

  // Read address: master address when a cycle starts, the next burst
  // address on an incrementing ack, otherwise the current beat again.
  // NOTE: every signal assigned here gets a default first so no latch is
  // inferred on the paths the case does not mention.
  always_comb begin
    w_rd_adr = r_cur_adr;
    case (r_state)
      IDLE:    w_rd_adr = wb.adr;
      RESP:    if (w_burst_next) w_rd_adr = w_next_adr;
      default: w_rd_adr = r_cur_adr;
    endcase
  end

  assign w_rd_idx = AW'(w_rd_adr - BASE_WORD);
  assign w_wr_idx = w_cur_off[AW-1:0];

  byte_en_ram #(
    .DEPTH(DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ack & wb.we),
    .i_be    (wb.sel),
    .i_waddr (w_wr_idx),
    .i_wdata (wb.dat_w),
    .i_raddr (w_rd_idx),
    .o_rdata (w_ram_q)
  );

  assign wb.ack   = w_ack;
  assign wb.err   = w_err;
  assign wb.dat_r = ((r_state == RESP) && w_in_range) ? w_ram_q : 32'd0;

  // Cycle FSM: capture the first address, count wait states, then
  // respond beat by beat until the burst ends, errors or cyc drops.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= 4'd0;
      r_cur_adr  <= 30'd0;
      r_bte      <= LINEAR;
    end else if (!wb.cyc) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (wb.stb) begin
            r_cur_adr <= wb.adr;
            r_bte     <= wb_bte_t'(wb.bte);
            if (WAIT_STATES > 0) begin
              r_state    <= WAIT;
              r_wait_cnt <= 4'(WAIT_STATES - 1);
            end else begin
              r_state <= RESP;
            end
          end
        end
        WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (w_err) begin
            r_state <= IDLE;
          end else if (w_ack) begin
            if (wb.cti == INCR) begin
              r_cur_adr <= w_next_adr;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_sram_responder.sv
// Bench for wishbone_sram_responder: two instances (no wait states at base
// 0; three wait states in a 16-word window at base 16) driven by a simple
// bus master, checked every cycle against a latency/address model plus
// literal expectations for each directed scenario.
module tb_wishbone_sram_responder;

  typedef logic [31:0] word_arr_t [16];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Master-side drive per instance.
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_we  [2];
  logic [29:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic [2:0]  m_cti [2];
  logic [1:0]  m_bte [2];

  logic        s_ack [2];
  logic        s_err [2];
  logic [31:0] s_dat [2];

  wishbone_interface wb0 ();
  wishbone_interface wb1 ();

  assign wb0.cyc = m_cyc[0];  assign wb1.cyc = m_cyc[1];
  assign wb0.stb = m_stb[0];  assign wb1.stb = m_stb[1];
  assign wb0.we  = m_we[0];   assign wb1.we  = m_we[1];
  assign wb0.adr = m_adr[0];  assign wb1.adr = m_adr[1];
  assign wb0.dat_w = m_dat[0]; assign wb1.dat_w = m_dat[1];
  assign wb0.sel = m_sel[0];  assign wb1.sel = m_sel[1];
  assign wb0.cti = m_cti[0];  assign wb1.cti = m_cti[1];
  assign wb0.bte = m_bte[0];  assign wb1.bte = m_bte[1];
  assign s_ack[0] = wb0.ack;  assign s_ack[1] = wb1.ack;
  assign s_err[0] = wb0.err;  assign s_err[1] = wb1.err;
  assign s_dat[0] = wb0.dat_r; assign s_dat[1] = wb1.dat_r;

  wishbone_sram_responder #(
    .DEPTH_WORDS(1024), .BASE_WORD(30'd0), .WAIT_STATES(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .wb(wb0)
  );

  wishbone_sram_responder #(
    .DEPTH_WORDS(16), .BASE_WORD(30'd16), .WAIT_STATES(3)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .wb(wb1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     ws_p    [2] = '{0, 3};
  longint base_p  [2] = '{0, 16};
  longint depth_p [2] = '{1024, 16};

  bit     mdl_busy [2];
  int     mdl_lat  [2];
  longint mdl_cur  [2];
  int     mdl_bte  [2];
  logic [31:0] mdl_mem [longint];

  function automatic bit mdl_in_range(input int d, input longint a);
    return (a >= base_p[d]) && (a - base_p[d] < depth_p[d]);
  endfunction

  function automatic longint mdl_next(input longint a, input int bte);
    longint n;
    if (bte == 0) return (a + 1) % (longint'(1) << 30);
    n = longint'(2) << bte;
    return a - (a % n) + ((a + 1) % n);
  endfunction

  function automatic longint mdl_key(input int d, input longint a);
    return (longint'(d) << 32) | a;
  endfunction

  // Compare both instances every cycle, then advance the model with the
  // inputs that will be sampled at the next rising edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit respond, inr;
      longint k;
      logic [31:0] w;
      if (!rst_n) begin
        check($sformatf("rst_ack[%0d]", d), 32'(s_ack[d]), 32'd0);
        check($sformatf("rst_err[%0d]", d), 32'(s_err[d]), 32'd0);
        check($sformatf("rst_dat[%0d]", d), s_dat[d], 32'd0);
        mdl_busy[d] = 1'b0;
        continue;
      end
      respond = mdl_busy[d] && (mdl_lat[d] == 0) && m_cyc[d] && m_stb[d];
      inr     = mdl_in_range(d, mdl_cur[d]);
      k       = mdl_key(d, mdl_cur[d]);
      check($sformatf("ack[%0d]", d), 32'(s_ack[d]), 32'(respond && inr));
      check($sformatf("err[%0d]", d), 32'(s_err[d]), 32'(respond && !inr));
      if (respond && inr && !m_we[d] && mdl_mem.exists(k))
        check($sformatf("dat[%0d]@%0d", d, mdl_cur[d]), s_dat[d], mdl_mem[k]);
      if (respond && !inr)
        check($sformatf("err_dat[%0d]", d), s_dat[d], 32'd0);

      if (!m_cyc[d]) begin
        mdl_busy[d] = 1'b0;
      end else if (!mdl_busy[d]) begin
        if (m_stb[d]) begin
          mdl_busy[d] = 1'b1;
          mdl_cur[d]  = longint'(m_adr[d]);
          mdl_bte[d]  = int'(m_bte[d]);
          mdl_lat[d]  = ws_p[d];
        end
      end else if (mdl_lat[d] > 0) begin
        mdl_lat[d]--;
      end else if (m_stb[d]) begin
        if (inr) begin
          if (m_we[d]) begin
            w = mdl_mem.exists(k) ? mdl_mem[k] : 32'd0;
            for (int b = 0; b < 4; b++)
              if (m_sel[d][b]) w[8*b +: 8] = m_dat[d][8*b +: 8];
            mdl_mem[k] = w;
          end
          if (m_cti[d] == 3'b010) mdl_cur[d] = mdl_next(mdl_cur[d], mdl_bte[d]);
          else                    mdl_busy[d] = 1'b0;
        end else begin
          mdl_busy[d] = 1'b0;
        end
      end
    end
  end

  // ---------------- bus master ----------------
  task automatic idle(input int d);
    m_cyc[d] = 1'b0; m_stb[d] = 1'b0; m_we[d] = 1'b0; m_cti[d] = 3'b000;
  endtask

  // Starts and ends at posedge+1. Master adr is held at the start address
  // for the whole burst; the responder must track beats itself.
  task automatic wb_burst(input int d, input bit we, input logic [29:0] adr,
                          input logic [1:0] bte, input logic [3:0] sel, input int n,
                          input word_arr_t wd, input int drop_after, input int stall_at,
                          output word_arr_t rd, output int first_lat, output int span,
                          output int n_ack, output bit saw_err);
    int first, last;
    bit stalled, done;
    first = -1; last = -1; stalled = 1'b0; done = 1'b0;
    n_ack = 0; saw_err = 1'b0; rd = '{default: 32'd0};
    m_cyc[d] = 1'b1; m_stb[d] = 1'b1; m_we[d] = we; m_adr[d] = adr;
    m_bte[d] = bte; m_sel[d] = sel; m_dat[d] = wd[0];
    m_cti[d] = (n == 1) ? 3'b000 : 3'b010;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (m_stb[d] && (s_ack[d] || s_err[d])) begin
        rd[n_ack] = s_dat[d];
        if (first < 0) first = c;
        if (s_err[d]) begin
          saw_err = 1'b1;
          done = 1'b1;
        end else begin
          last = c;
          n_ack++;
        end
      end
      if (n_ack == n || (drop_after > 0 && n_ack == drop_after)) done = 1'b1;
      if (!done) begin
        @(posedge clk); #1;
        if (stall_at > 0 && n_ack == stall_at && !stalled) begin
          m_stb[d] = 1'b0;
          stalled = 1'b1;
        end else begin
          m_stb[d] = 1'b1;
        end
        m_dat[d] = wd[n_ack];
        m_cti[d] = (n_ack == n - 1) ? ((n == 1) ? 3'b000 : 3'b111) : 3'b010;
      end
    end
    if (!done) check("bus_timeout", 32'd0, 32'd1);
    first_lat = first;
    span = last - first;
    @(posedge clk); #1;
    idle(d);
  endtask

  task automatic wb_single(input int d, input bit we, input logic [29:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           output logic [31:0] rdat, output int lat, output bit saw_err);
    word_arr_t w, r;
    int sp, na;
    w = '{default: 32'd0};
    w[0] = dat;
    wb_burst(d, we, adr, 2'b00, sel, 1, w, 0, 0, r, lat, sp, na, saw_err);
    rdat = r[0];
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    word_arr_t wd, rd;
    logic [31:0] rdat;
    int lat, span, nack, acks;
    bit err;

    for (int d = 0; d < 2; d++) begin
      idle(d);
      m_adr[d] = '0; m_dat[d] = '0; m_sel[d] = '0; m_bte[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Classic write then read, no wait states.
    wb_single(0, 1'b1, 30'd5, 32'hDEADBEEF, 4'hF, rdat, lat, err);
    check("t1_wr_lat", 32'(lat), 32'd1);
    wb_single(0, 1'b0, 30'd5, 32'd0, 4'hF, rdat, lat, err);
    check("t1_rd_lat", 32'(lat), 32'd1);
    check("t1_rd_dat", rdat, 32'hDEADBEEF);

    // Byte-lane write.
    wb_single(0, 1'b1, 30'd9, 32'h11223344, 4'hF, rdat, lat, err);
    wb_single(0, 1'b1, 30'd9, 32'h0000AB00, 4'b0010, rdat, lat, err);
    wb_single(0, 1'b0, 30'd9, 32'd0, 4'hF, rdat, lat, err);
    check("t2_sel_dat", rdat, 32'h1122AB44);

    // Wrap-4 burst read from word 6 over words 4..7.
    wd = '{default: 32'd0};
    wd[0] = 32'hA0A0A0A0; wd[1] = 32'hB0B0B0B0; wd[2] = 32'hC0C0C0C0; wd[3] = 32'hD0D0D0D0;
    wb_burst(0, 1'b1, 30'd4, 2'b00, 4'hF, 4, wd, 0, 0, rd, lat, span, nack, err);
    check("t3_wburst_span", 32'(span), 32'd3);
    wb_burst(0, 1'b0, 30'd6, 2'b01, 4'hF, 4, wd, 0, 0, rd, lat, span, nack, err);
    check("t3_wrap4_lat", 32'(lat), 32'd1);
    check("t3_wrap4_span", 32'(span), 32'd3);
    check("t3_wrap4_d0", rd[0], 32'hC0C0C0C0);
    check("t3_wrap4_d1", rd[1], 32'hD0D0D0D0);
    check("t3_wrap4_d2", rd[2], 32'hA0A0A0A0);
    check("t3_wrap4_d3", rd[3], 32'hB0B0B0B0);
    wb_single(0, 1'b0, 30'd4, 32'd0, 4'hF, rdat, lat, err);
    check("t3_idle_after_lat", 32'(lat), 32'd1);

    // Words 16..31 for wrap-8 / wrap-16 and later scenarios.
    for (int i = 0; i < 16; i++) wd[i] = 32'h1000 + 32'(i);
    wb_burst(0, 1'b1, 30'd16, 2'b00, 4'hF, 16, wd, 0, 0, rd, lat, span, nack, err);
    check("lin16_span", 32'(span), 32'd15);
    wb_burst(0, 1'b0, 30'd21, 2'b10, 4'hF, 4, wd, 0, 0, rd, lat, span, nack, err);
    check("wrap8_d2", rd[2], 32'h1007);
    check("wrap8_d3", rd[3], 32'h1000);
    wb_burst(0, 1'b0, 30'd30, 2'b11, 4'hF, 4, wd, 0, 1, rd, lat, span, nack, err);
    check("wrap16_stall_span", 32'(span), 32'd4);
    check("wrap16_d1", rd[1], 32'h100F);
    check("wrap16_d2", rd[2], 32'h1000);
    check("wrap16_d3", rd[3], 32'h1001);

    // Three wait states, window at base 16.
    wb_single(1, 1'b1, 30'd20, 32'h44440020, 4'hF, rdat, lat, err);
    check("t4_wr_lat", 32'(lat), 32'd4);
    wb_single(1, 1'b0, 30'd20, 32'd0, 4'hF, rdat, lat, err);
    check("t4_rd_lat", 32'(lat), 32'd4);
    check("t4_rd_dat", rdat, 32'h44440020);
    for (int i = 0; i < 4; i++) wd[i] = 32'h2400 + 32'(i);
    wb_burst(1, 1'b1, 30'd24, 2'b00, 4'hF, 4, wd, 0, 0, rd, lat, span, nack, err);
    wb_burst(1, 1'b0, 30'd24, 2'b00, 4'hF, 4, wd, 0, 0, rd, lat, span, nack, err);
    check("t4_burst_lat", 32'(lat), 32'd4);
    check("t4_burst_span", 32'(span), 32'd3);
    check("t4_burst_d3", rd[3], 32'h2403);

    // Out-of-window accesses.
    wb_single(0, 1'b1, 30'd0, 32'h5A5A5A5A, 4'hF, rdat, lat, err);
    wb_single(0, 1'b0, 30'd1024, 32'd0, 4'hF, rdat, lat, err);
    check("t5_top_err", 32'(err), 32'd1);
    check("t5_top_dat", rdat, 32'd0);
    check("t5_top_lat", 32'(lat), 32'd1);
    wb_single(1, 1'b0, 30'd15, 32'd0, 4'hF, rdat, lat, err);
    check("t5_below_err", 32'(err), 32'd1);
    wb_single(1, 1'b0, 30'd32, 32'd0, 4'hF, rdat, lat, err);
    check("t5_above_err", 32'(err), 32'd1);
    for (int i = 0; i < 4; i++) wd[i] = {4{4'hE, 4'(i)}};
    wb_burst(0, 1'b1, 30'd1022, 2'b00, 4'hF, 4, wd, 0, 0, rd, lat, span, nack, err);
    check("t5_cross_acks", 32'(nack), 32'd2);
    check("t5_cross_err", 32'(err), 32'd1);
    wb_single(0, 1'b0, 30'd1023, 32'd0, 4'hF, rdat, lat, err);
    check("t5_cross_last", rdat, 32'hE1E1E1E1);
    wb_single(0, 1'b0, 30'd0, 32'd0, 4'hF, rdat, lat, err);
    check("t5_no_alias_wr", rdat, 32'h5A5A5A5A);

    // cyc dropped after beat 2 of an 8-beat burst.
    wb_burst(0, 1'b0, 30'd16, 2'b00, 4'hF, 8, wd, 2, 0, rd, lat, span, nack, err);
    check("t6_drop_acks", 32'(nack), 32'd2);
    check("t6_drop_d1", rd[1], 32'h1001);
    repeat (3) @(posedge clk);
    #1;
    wb_single(0, 1'b0, 30'd17, 32'd0, 4'hF, rdat, lat, err);
    check("t6_after_drop_lat", 32'(lat), 32'd1);
    check("t6_after_drop_dat", rdat, 32'h1001);

    // Reset pulse in the middle of a burst.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 30'd16;
    m_bte[0] = 2'b00; m_sel[0] = 4'hF; m_cti[0] = 3'b010;
    acks = 0;
    for (int c = 0; c < 20 && acks < 2; c++) begin
      @(negedge clk);
      if (s_ack[0]) acks++;
      if (acks < 2) begin @(posedge clk); #1; end
    end
    check("t6_pre_rst_acks", 32'(acks), 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_ack", 32'(s_ack[0]), 32'd0);
    @(posedge clk); #1;
    idle(0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wb_single(0, 1'b0, 30'd18, 32'd0, 4'hF, rdat, lat, err);
    check("t6_post_rst_lat", 32'(lat), 32'd1);
    check("t6_post_rst_dat", rdat, 32'h1002);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
